// File: rtl/hub75_scan_pkg.sv
// rtl/hub75_scan_pkg.sv - shared types and row-map helper for the HUB75 scan sequencer
package hub75_scan_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_LOAD,
      ST_WAIT_BCM,
      ST_PAINT,
      ST_FEND
   } state_e;

   typedef enum logic [1:0] {
      MODE_LINEAR,
      MODE_ZIGZAG,
      MODE_INTERLACE
   } scan_mode_e;

   // Wide enough for any sensible row-address width; callers truncate.
   localparam int MAP_W = 16;

   // Scan index -> physical row. log_n is the live address width, so the
   // bit rotations below are expressed as shifts by constants.
   function automatic logic [MAP_W-1:0] row_map(input logic [MAP_W-1:0] idx,
                                                input int unsigned log_n,
                                                input scan_mode_e mode);
      logic [MAP_W-1:0] mask;
      mask = (MAP_W'(1) << log_n) - MAP_W'(1);
      case (mode)
         // {i[0], i[LOG-1:1]}: even rows first half, odd rows second half
         MODE_ZIGZAG:    row_map = (idx >> 1) | ((idx & MAP_W'(1)) << (log_n - 1));
         // {i[LOG-2:0], i[LOG-1]}: even rows, then odd rows
         MODE_INTERLACE: row_map = ((idx << 1) & mask) | ((idx >> (log_n - 1)) & MAP_W'(1));
         default:        row_map = idx;
      endcase
   endfunction

endpackage

// File: rtl/hub75_scan_seq_if.sv
// rtl/hub75_scan_seq_if.sv - framebuffer and BCM handshake bundle of the scan sequencer
interface hub75_scan_seq_if #(
   parameter int LOG_N_ROWS = 5
);
   logic                  frame_swap;
   logic                  frame_rdy;
   logic                  fb_frame_swap;
   logic [LOG_N_ROWS-1:0] fb_row_addr;
   logic                  fb_row_load;
   logic                  fb_row_rdy;
   logic                  fb_row_swap;
   logic [LOG_N_ROWS-1:0] bcm_row;
   logic                  bcm_row_first;
   logic                  bcm_go;
   logic                  bcm_rdy;

   modport master (
      input  frame_swap, fb_row_rdy, bcm_rdy,
      output frame_rdy, fb_frame_swap, fb_row_addr, fb_row_load, fb_row_swap,
             bcm_row, bcm_row_first, bcm_go
   );

   modport slave (
      output frame_swap, fb_row_rdy, bcm_rdy,
      input  frame_rdy, fb_frame_swap, fb_row_addr, fb_row_load, fb_row_swap,
             bcm_row, bcm_row_first, bcm_go
   );
endinterface

// File: rtl/hub75_scan_map.sv
// rtl/hub75_scan_map.sv - combinational scan index to physical row mapping
module hub75_scan_map
   import hub75_scan_pkg::*;
#(
   parameter int         LOG_N_ROWS = 5,
   parameter scan_mode_e MODE       = MODE_ZIGZAG
) (
   input  logic [LOG_N_ROWS-1:0] idx,
   output logic [LOG_N_ROWS-1:0] addr
);

   // Pure rewiring of the index bits for the selected scan order.
   always_comb begin
      addr = LOG_N_ROWS'(row_map(MAP_W'(idx), LOG_N_ROWS, MODE));
   end

endmodule

// File: rtl/hub75_scan_seq.sv
// rtl/hub75_scan_seq.sv - row scan sequencer with frame-swap arbitration for HUB75
module hub75_scan_seq
   import hub75_scan_pkg::*;
#(
   parameter int    N_ROWS     = 32,
   parameter string SCAN_MODE  = "ZIGZAG",
   parameter int    REPEAT_W   = 8,
   parameter int    FCNT_W     = 16,
   parameter int    LOG_N_ROWS = $clog2(N_ROWS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ctrl_run,
   input  logic [LOG_N_ROWS-1:0] cfg_row_last,
   input  logic [REPEAT_W-1:0]   cfg_frame_repeat,
   output logic                  scan_busy,
   output logic [FCNT_W-1:0]     frame_cnt,
   hub75_scan_seq_if.master      bus
);

   localparam scan_mode_e MODE = (SCAN_MODE == "LINEAR")    ? MODE_LINEAR :
                                 (SCAN_MODE == "INTERLACE") ? MODE_INTERLACE :
                                                              MODE_ZIGZAG;
   localparam logic [LOG_N_ROWS-1:0] ROW_MAX = LOG_N_ROWS'(N_ROWS - 1);
   localparam logic [REPEAT_W-1:0]   RC_MAX  = '1;

   state_e                state, state_next;
   logic                  pending, pending_next;
   logic                  swap_exec;
   logic [REPEAT_W-1:0]   rc, rc_next;
   logic [REPEAT_W:0]     rc_inc;
   logic [LOG_N_ROWS-1:0] idx, idx_next;
   logic [LOG_N_ROWS-1:0] row_last, row_last_next;
   logic [LOG_N_ROWS-1:0] last_idx;
   logic [LOG_N_ROWS-1:0] row_addr;
   logic [FCNT_W-1:0]     frame_cnt_next;

   // One shared index feeds both the load address and the paint address,
   // so the row loaded ahead is always the row painted next.
   hub75_scan_map #(
      .LOG_N_ROWS (LOG_N_ROWS),
      .MODE       (MODE)
   ) u_map (
      .idx  (idx),
      .addr (row_addr)
   );

   assign rc_inc   = {1'b0, rc} + (REPEAT_W + 1)'(1);
   assign last_idx = (MODE == MODE_LINEAR) ? row_last : ROW_MAX;

   assign pending_next      = (pending & ~swap_exec) | bus.frame_swap;
   assign bus.frame_rdy     = ~pending;
   assign bus.fb_frame_swap = swap_exec;
   assign scan_busy         = (state != ST_IDLE);

   // State and counter registers; reset aborts whatever is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         pending   <= 1'b0;
         rc        <= '0;
         idx       <= '0;
         row_last  <= '0;
         frame_cnt <= '0;
      end else begin
         state     <= state_next;
         pending   <= pending_next;
         rc        <= rc_next;
         idx       <= idx_next;
         row_last  <= row_last_next;
         frame_cnt <= frame_cnt_next;
      end
   end

   // Next-state, counter updates and single-cycle strobes.
   always_comb begin
      state_next        = state;
      idx_next          = idx;
      rc_next           = rc;
      row_last_next     = row_last;
      frame_cnt_next    = frame_cnt;
      swap_exec         = 1'b0;
      bus.fb_row_load   = 1'b0;
      bus.fb_row_addr   = '0;
      bus.fb_row_swap   = 1'b0;
      bus.bcm_go        = 1'b0;
      bus.bcm_row       = '0;
      bus.bcm_row_first = 1'b0;

      case (state)
         ST_IDLE: begin
            // A pending swap wins over starting a frame; the scan starts
            // one cycle later if ctrl_run is still set.
            if (pending) begin
               swap_exec = 1'b1;
               rc_next   = '0;
            end else if (ctrl_run) begin
               idx_next      = '0;
               row_last_next = cfg_row_last;
               state_next    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            bus.fb_row_load = 1'b1;
            bus.fb_row_addr = row_addr;
            state_next      = ST_WAIT_LOAD;
         end
         ST_WAIT_LOAD: begin
            // Skipping WAIT_BCM when the BCM is already idle keeps
            // PAINT-to-PAINT spacing at three cycles.
            if (bus.fb_row_rdy) begin
               state_next = bus.bcm_rdy ? ST_PAINT : ST_WAIT_BCM;
            end
         end
         ST_WAIT_BCM: begin
            if (bus.bcm_rdy) begin
               state_next = ST_PAINT;
            end
         end
         ST_PAINT: begin
            bus.fb_row_swap   = 1'b1;
            bus.bcm_go        = 1'b1;
            bus.bcm_row       = row_addr;
            bus.bcm_row_first = (idx == '0);
            if (idx != last_idx) begin
               idx_next   = idx + LOG_N_ROWS'(1);
               state_next = ST_LOAD;
            end else begin
               state_next = ST_FEND;
            end
         end
         ST_FEND: begin
            // Frame boundary: the only point mid-scan where a swap may fire,
            // and only once the BCM has finished the last row.
            if (bus.bcm_rdy) begin
               frame_cnt_next = frame_cnt + FCNT_W'(1);
               rc_next        = (rc == RC_MAX) ? rc : rc + REPEAT_W'(1);
               if (pending && (rc_inc >= {1'b0, cfg_frame_repeat})) begin
                  swap_exec = 1'b1;
                  rc_next   = '0;
               end
               if (ctrl_run) begin
                  idx_next      = '0;
                  row_last_next = cfg_row_last;
                  state_next    = ST_LOAD;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_hub75_scan_seq.sv
// tb/tb_hub75_scan_seq.sv - scoreboard bench for the HUB75 scan sequencer
module tb_hub75_scan_seq;

   typedef struct packed {
      logic [2:0]  row;
      logic        first;
      logic [15:0] fcnt;
   } go_t;

   typedef struct packed {
      logic [15:0] fcnt;
      logic        rdy_after;
   } sw_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ctrl_run_l = 1'b0;
   logic        ctrl_run_z = 1'b0;
   logic        ctrl_run_i = 1'b0;
   logic [2:0]  cfg_row_last = 3'd7;
   logic [7:0]  cfg_frame_repeat = 8'd1;
   logic        scan_busy_l, scan_busy_z, scan_busy_i;
   logic [15:0] frame_cnt_l, frame_cnt_z, frame_cnt_i;

   int total = 0;
   int bad = 0;
   int loads_seen = 0;
   int gos_seen = 0;
   bit rdy_pend = 1'b0;
   bit rdy_exp = 1'b0;

   go_t        q_go_l[$], q_go_z[$], q_go_i[$];
   logic [2:0] q_ld_l[$], q_ld_z[$], q_ld_i[$];
   sw_t        q_sw_l[$];

   hub75_scan_seq_if #(.LOG_N_ROWS(3)) if_l ();
   hub75_scan_seq_if #(.LOG_N_ROWS(3)) if_z ();
   hub75_scan_seq_if #(.LOG_N_ROWS(3)) if_i ();

   hub75_scan_seq #(.N_ROWS(8), .SCAN_MODE("LINEAR")) dut_l (
      .clk(clk), .rst(rst), .ctrl_run(ctrl_run_l), .cfg_row_last(cfg_row_last),
      .cfg_frame_repeat(cfg_frame_repeat), .scan_busy(scan_busy_l),
      .frame_cnt(frame_cnt_l), .bus(if_l.master)
   );

   hub75_scan_seq #(.N_ROWS(8), .SCAN_MODE("ZIGZAG")) dut_z (
      .clk(clk), .rst(rst), .ctrl_run(ctrl_run_z), .cfg_row_last(3'd0),
      .cfg_frame_repeat(cfg_frame_repeat), .scan_busy(scan_busy_z),
      .frame_cnt(frame_cnt_z), .bus(if_z.master)
   );

   hub75_scan_seq #(.N_ROWS(8), .SCAN_MODE("INTERLACE")) dut_i (
      .clk(clk), .rst(rst), .ctrl_run(ctrl_run_i), .cfg_row_last(3'd0),
      .cfg_frame_repeat(cfg_frame_repeat), .scan_busy(scan_busy_i),
      .frame_cnt(frame_cnt_i), .bus(if_i.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit cond_met(input int sel, input int target);
      case (sel)
         0:       return frame_cnt_l == 16'(target);
         1:       return scan_busy_l == 1'(target);
         2:       return (scan_busy_z == 1'b0) && (scan_busy_i == 1'b0);
         3:       return if_l.bcm_go == 1'b1;
         default: return 1'b1;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int target, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cond_met(sel, target) && n < 2000);
      chk({name, "_reached"}, 32'(cond_met(sel, target)), 32'd1);
   endtask

   task automatic push_frames_l(input int nframes, input int nrows, input int fcnt0);
      go_t e;
      for (int f = 0; f < nframes; f++) begin
         for (int r = 0; r < nrows; r++) begin
            e.row   = 3'(r);
            e.first = (r == 0);
            e.fcnt  = 16'(fcnt0 + f);
            q_go_l.push_back(e);
            q_ld_l.push_back(3'(r));
         end
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_frame_rdy"},     32'(if_l.frame_rdy), 32'd1);
      chk({tag, "_fb_frame_swap"}, 32'(if_l.fb_frame_swap), 32'd0);
      chk({tag, "_fb_row_addr"},   32'(if_l.fb_row_addr), 32'd0);
      chk({tag, "_fb_row_load"},   32'(if_l.fb_row_load), 32'd0);
      chk({tag, "_fb_row_swap"},   32'(if_l.fb_row_swap), 32'd0);
      chk({tag, "_bcm_row"},       32'(if_l.bcm_row), 32'd0);
      chk({tag, "_bcm_row_first"}, 32'(if_l.bcm_row_first), 32'd0);
      chk({tag, "_bcm_go"},        32'(if_l.bcm_go), 32'd0);
      chk({tag, "_scan_busy"},     32'(scan_busy_l), 32'd0);
      chk({tag, "_frame_cnt"},     32'(frame_cnt_l), 32'd0);
   endtask

   // Monitor: pops the scoreboard whenever any DUT presents a strobe.
   initial begin
      go_t        e;
      sw_t        s;
      logic [2:0] a;
      forever begin
         @(negedge clk);
         if (rdy_pend) begin
            chk("frame_rdy_after_swap", 32'(if_l.frame_rdy), 32'(rdy_exp));
            rdy_pend = 1'b0;
         end
         if ((32'(if_l.bcm_go === 1'b1) + 32'(if_l.fb_row_load === 1'b1) +
              32'(if_l.fb_frame_swap === 1'b1)) > 32'd1)
            chk("l_strobe_overlap", 32'd1, 32'd0);
         if ((if_l.fb_row_swap === 1'b1) != (if_l.bcm_go === 1'b1))
            chk("l_row_swap_vs_go", 32'(if_l.fb_row_swap), 32'(if_l.bcm_go));
         if (if_l.bcm_go === 1'b1) begin
            gos_seen++;
            if (q_go_l.size() == 0) chk("l_go_unexpected", 32'd1, 32'd0);
            else begin
               e = q_go_l.pop_front();
               chk("l_bcm_row", 32'(if_l.bcm_row), 32'(e.row));
               chk("l_bcm_row_first", 32'(if_l.bcm_row_first), 32'(e.first));
               chk("l_frame_cnt_at_go", 32'(frame_cnt_l), 32'(e.fcnt));
            end
         end
         if (if_l.fb_row_load === 1'b1) begin
            loads_seen++;
            if (q_ld_l.size() == 0) chk("l_load_unexpected", 32'd1, 32'd0);
            else begin
               a = q_ld_l.pop_front();
               chk("l_fb_row_addr", 32'(if_l.fb_row_addr), 32'(a));
            end
         end
         if (if_l.fb_frame_swap === 1'b1) begin
            if (q_sw_l.size() == 0) chk("l_swap_unexpected", 32'd1, 32'd0);
            else begin
               s = q_sw_l.pop_front();
               chk("swap_frame_cnt", 32'(frame_cnt_l), 32'(s.fcnt));
               chk("swap_bcm_rdy", 32'(if_l.bcm_rdy), 32'd1);
               rdy_pend = 1'b1;
               rdy_exp  = s.rdy_after;
            end
         end
         if (if_z.bcm_go === 1'b1) begin
            if (q_go_z.size() == 0) chk("z_go_unexpected", 32'd1, 32'd0);
            else begin
               e = q_go_z.pop_front();
               chk("z_bcm_row", 32'(if_z.bcm_row), 32'(e.row));
               chk("z_bcm_row_first", 32'(if_z.bcm_row_first), 32'(e.first));
            end
         end
         if (if_z.fb_row_load === 1'b1) begin
            if (q_ld_z.size() == 0) chk("z_load_unexpected", 32'd1, 32'd0);
            else begin
               a = q_ld_z.pop_front();
               chk("z_fb_row_addr", 32'(if_z.fb_row_addr), 32'(a));
            end
         end
         if (if_i.bcm_go === 1'b1) begin
            if (q_go_i.size() == 0) chk("i_go_unexpected", 32'd1, 32'd0);
            else begin
               e = q_go_i.pop_front();
               chk("i_bcm_row", 32'(if_i.bcm_row), 32'(e.row));
               chk("i_bcm_row_first", 32'(if_i.bcm_row_first), 32'(e.first));
            end
         end
         if (if_i.fb_row_load === 1'b1) begin
            if (q_ld_i.size() == 0) chk("i_load_unexpected", 32'd1, 32'd0);
            else begin
               a = q_ld_i.pop_front();
               chk("i_fb_row_addr", 32'(if_i.fb_row_addr), 32'(a));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1);
   end

   // Stimulus: directed phases, expected responses pushed as issued.
   initial begin
      logic [2:0] zz_rows [8];
      logic [2:0] il_rows [8];
      go_t        e;
      sw_t        s;
      int         l0, g0;

      zz_rows = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd7};
      il_rows = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd1, 3'd3, 3'd5, 3'd7};

      if_l.frame_swap = 1'b0; if_l.fb_row_rdy = 1'b1; if_l.bcm_rdy = 1'b1;
      if_z.frame_swap = 1'b0; if_z.fb_row_rdy = 1'b1; if_z.bcm_rdy = 1'b1;
      if_i.frame_swap = 1'b0; if_i.fb_row_rdy = 1'b1; if_i.bcm_rdy = 1'b1;

      // Reset values
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("reset");

      // LINEAR 8 rows, two frames, ctrl_run dropped mid second frame
      push_frames_l(2, 8, 0);
      tick();
      ctrl_run_l = 1'b1;
      wait_for(0, 1, "lin_frame1");
      tick();
      ctrl_run_l = 1'b0;
      wait_for(1, 0, "lin_idle");
      chk("lin_frame_cnt", 32'(frame_cnt_l), 32'd2);
      chk("lin_go_left", 32'(q_go_l.size()), 32'd0);
      chk("lin_load_left", 32'(q_ld_l.size()), 32'd0);

      // ZIGZAG and INTERLACE, one frame each
      for (int r = 0; r < 8; r++) begin
         e.row = zz_rows[r]; e.first = (r == 0); e.fcnt = 16'd0;
         q_go_z.push_back(e); q_ld_z.push_back(zz_rows[r]);
         e.row = il_rows[r];
         q_go_i.push_back(e); q_ld_i.push_back(il_rows[r]);
      end
      tick();
      ctrl_run_z = 1'b1; ctrl_run_i = 1'b1;
      tick();
      ctrl_run_z = 1'b0; ctrl_run_i = 1'b0;
      wait_for(2, 0, "zi_idle");
      chk("zz_frame_cnt", 32'(frame_cnt_z), 32'd1);
      chk("il_frame_cnt", 32'(frame_cnt_i), 32'd1);
      chk("zz_go_left", 32'(q_go_z.size()), 32'd0);
      chk("il_go_left", 32'(q_go_i.size()), 32'd0);

      // Frame repeat 3: swap requested in frame 0 fires at end of frame 2
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cfg_frame_repeat = 8'd3;
      push_frames_l(4, 8, 0);
      s.fcnt = 16'd2; s.rdy_after = 1'b1;
      q_sw_l.push_back(s);
      ctrl_run_l = 1'b1;
      repeat (5) tick();
      if_l.frame_swap = 1'b1;
      tick();
      if_l.frame_swap = 1'b0;
      @(negedge clk);
      chk("rep_frame_rdy_drop", 32'(if_l.frame_rdy), 32'd0);
      wait_for(0, 3, "rep_frame3");
      tick();
      ctrl_run_l = 1'b0;
      wait_for(1, 0, "rep_idle");
      chk("rep_frame_cnt", 32'(frame_cnt_l), 32'd4);
      chk("rep_swap_left", 32'(q_sw_l.size()), 32'd0);
      chk("rep_go_left", 32'(q_go_l.size()), 32'd0);

      // Idle swap, with a second request landing in the execute cycle
      s.fcnt = 16'd4; s.rdy_after = 1'b0;
      q_sw_l.push_back(s);
      s.rdy_after = 1'b1;
      q_sw_l.push_back(s);
      tick();
      if_l.frame_swap = 1'b1;
      tick();
      tick();
      if_l.frame_swap = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_swap_left", 32'(q_sw_l.size()), 32'd0);
      chk("idle_swap_busy", 32'(scan_busy_l), 32'd0);
      chk("idle_swap_frame_rdy", 32'(if_l.frame_rdy), 32'd1);

      // LINEAR 4 rows with the BCM stalled 20 cycles after the first PAINT
      cfg_row_last = 3'd3;
      push_frames_l(1, 4, 4);
      tick();
      ctrl_run_l = 1'b1;
      tick();
      ctrl_run_l = 1'b0;
      wait_for(3, 1, "stall_first_go");
      tick();
      if_l.bcm_rdy = 1'b0;
      l0 = loads_seen;
      g0 = gos_seen;
      repeat (20) @(negedge clk);
      chk("stall_loads", 32'(loads_seen - l0), 32'd1);
      chk("stall_gos", 32'(gos_seen - g0), 32'd0);
      chk("stall_busy", 32'(scan_busy_l), 32'd1);
      tick();
      if_l.bcm_rdy = 1'b1;
      wait_for(1, 0, "stall_idle");
      chk("stall_frame_cnt", 32'(frame_cnt_l), 32'd5);
      chk("stall_go_left", 32'(q_go_l.size()), 32'd0);

      // Reset while parked in WAIT_BCM
      if_l.bcm_rdy = 1'b0;
      q_ld_l.push_back(3'd0);
      tick();
      ctrl_run_l = 1'b1;
      tick();
      ctrl_run_l = 1'b0;
      repeat (5) @(negedge clk);
      chk("wbcm_busy", 32'(scan_busy_l), 32'd1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("midrst");
      chk("midrst_load_left", 32'(q_ld_l.size()), 32'd0);
      if_l.bcm_rdy = 1'b1;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
